// File: rtl/uart_command_sender.sv
// Turns debounced button presses into one-byte UART commands. Each command is
// retried on ack timeout, and the outcome is reported as strobes and saturating counters.
module uart_command_sender #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btnU,
    input  logic       btnL,
    input  logic       btnD,
    input  logic       btnR,
    input  logic       btnC,
    input  logic [1:0] sw,
    output logic [7:0] tx_data,
    output logic       tx_transmit,
    input  logic       tx_idle,
    input  logic [7:0] rx_data,
    input  logic       rx_receive,
    output logic       busy,
    output logic       ack_ok,
    output logic       error,
    output logic [7:0] last_cmd,
    output logic [7:0] ack_count,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK
    } state_t;

    // Bit order sets the priority: U is bit 0 and wins over everything else.
    logic [4:0] btn_raw;
    logic [4:0] edge_vec;
    assign btn_raw = {btnC, btnR, btnD, btnL, btnU};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;
            logic edge_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                    edge_reg  <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                    edge_reg  <= sync2_reg & ~prev_reg;
                end
            end

            assign edge_vec[gi] = edge_reg;
        end
    endgenerate

    logic       new_valid;
    logic [7:0] new_cmd;

    always_comb begin
        new_valid = |edge_vec;
        new_cmd   = 8'h00;
        if (edge_vec[0]) begin
            new_cmd = 8'h77;
        end else if (edge_vec[1]) begin
            new_cmd = 8'h61;
        end else if (edge_vec[2]) begin
            new_cmd = 8'h73;
        end else if (edge_vec[3]) begin
            new_cmd = 8'h64;
        end else if (edge_vec[4]) begin
            case (sw)
                2'b00:   new_cmd = 8'h20;
                2'b01:   new_cmd = 8'h63;
                2'b10:   new_cmd = 8'h6D;
                default: new_cmd = 8'h79;
            endcase
        end
    end

    function automatic logic [7:0] ack_for(input logic [7:0] cmd);
        case (cmd)
            8'h77:   ack_for = 8'h57;
            8'h61:   ack_for = 8'h41;
            8'h73:   ack_for = 8'h53;
            8'h64:   ack_for = 8'h44;
            8'h20:   ack_for = 8'h5A;
            8'h63:   ack_for = 8'h43;
            8'h6D:   ack_for = 8'h4D;
            8'h79:   ack_for = 8'h59;
            default: ack_for = 8'h00;
        endcase
    endfunction

    state_t        state_reg;
    logic          pend_valid_reg;
    logic [7:0]    pend_cmd_reg;
    logic [7:0]    cmd_reg;
    logic [7:0]    exp_ack_reg;
    logic [TW-1:0] timeout_reg;
    logic [RW-1:0] retry_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_transmit_reg;
    logic          busy_reg;
    logic          ack_ok_reg;
    logic          error_reg;
    logic [7:0]    last_cmd_reg;
    logic [7:0]    ack_count_reg;
    logic [7:0]    err_count_reg;

    // A fresh edge takes precedence over consumption, so a press landing in
    // the same cycle IDLE takes the old entry refills the buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_reg <= 1'b0;
            pend_cmd_reg   <= 8'h00;
        end else if (new_valid) begin
            pend_valid_reg <= 1'b1;
            pend_cmd_reg   <= new_cmd;
        end else if (state_reg == IDLE && pend_valid_reg) begin
            pend_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            cmd_reg         <= 8'h00;
            exp_ack_reg     <= 8'h00;
            timeout_reg     <= '0;
            retry_reg       <= '0;
            tx_data_reg     <= 8'h00;
            tx_transmit_reg <= 1'b0;
            busy_reg        <= 1'b0;
            ack_ok_reg      <= 1'b0;
            error_reg       <= 1'b0;
            last_cmd_reg    <= 8'h00;
            ack_count_reg   <= 8'h00;
            err_count_reg   <= 8'h00;
        end else begin
            tx_transmit_reg <= 1'b0;
            ack_ok_reg      <= 1'b0;
            error_reg       <= 1'b0;
            busy_reg        <= (state_reg != IDLE);

            case (state_reg)
                IDLE: begin
                    if (pend_valid_reg) begin
                        cmd_reg      <= pend_cmd_reg;
                        exp_ack_reg  <= ack_for(pend_cmd_reg);
                        last_cmd_reg <= pend_cmd_reg;
                        retry_reg    <= '0;
                        state_reg    <= SEND;
                    end
                end

                SEND: begin
                    if (tx_idle) begin
                        tx_data_reg     <= cmd_reg;
                        tx_transmit_reg <= 1'b1;
                        timeout_reg     <= '0;
                        state_reg       <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    // A matching ack is checked first so it beats a coincident timeout.
                    if (rx_receive && rx_data == exp_ack_reg) begin
                        ack_ok_reg <= 1'b1;
                        if (ack_count_reg != 8'hFF) begin
                            ack_count_reg <= ack_count_reg + 8'd1;
                        end
                        state_reg <= IDLE;
                    end else if (timeout_reg == TIMEOUT_LAST) begin
                        if (retry_reg != RETRY_LAST) begin
                            retry_reg <= retry_reg + 1'b1;
                            state_reg <= SEND;
                        end else begin
                            error_reg <= 1'b1;
                            if (err_count_reg != 8'hFF) begin
                                err_count_reg <= err_count_reg + 8'd1;
                            end
                            state_reg <= IDLE;
                        end
                    end else begin
                        timeout_reg <= timeout_reg + 1'b1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tx_data     = tx_data_reg;
    assign tx_transmit = tx_transmit_reg;
    assign busy        = busy_reg;
    assign ack_ok      = ack_ok_reg;
    assign error       = error_reg;
    assign last_cmd    = last_cmd_reg;
    assign ack_count   = ack_count_reg;
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_uart_command_sender.sv
// Scoreboard bench for uart_command_sender: expected command bytes are queued
// when a button is pressed and checked against every tx_transmit pulse.
module tb_uart_command_sender;

    localparam int TO = 100;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btnU = 1'b0, btnL = 1'b0, btnD = 1'b0, btnR = 1'b0, btnC = 1'b0;
    logic [1:0] sw = 2'b00;
    logic [7:0] tx_data;
    logic       tx_transmit;
    logic       tx_idle = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_receive = 1'b0;
    logic       busy, ack_ok, error;
    logic [7:0] last_cmd, ack_count, err_count;

    uart_command_sender #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset_n(reset_n),
        .btnU(btnU), .btnL(btnL), .btnD(btnD), .btnR(btnR), .btnC(btnC),
        .sw(sw), .tx_data(tx_data), .tx_transmit(tx_transmit), .tx_idle(tx_idle),
        .rx_data(rx_data), .rx_receive(rx_receive), .busy(busy),
        .ack_ok(ack_ok), .error(error), .last_cmd(last_cmd),
        .ack_count(ack_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int tx_pulses = 0;
    logic [7:0] exp_tx_q[$];
    logic [7:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every transmitted byte must match the oldest expectation.
    always @(negedge clk) begin
        if (tx_transmit) begin
            tx_pulses++;
            compared++;
            if (exp_tx_q.size() == 0) begin
                mismatched++;
                $display("FAIL tx_unexpected: got tx_data=%02h, nothing expected", tx_data);
            end else begin
                mon_exp = exp_tx_q.pop_front();
                if (tx_data !== mon_exp) begin
                    mismatched++;
                    $display("FAIL tx_data: got %02h, expected %02h", tx_data, mon_exp);
                end else begin
                    $display("tx byte %02h at cycle %0d", tx_data, cyc);
                end
            end
        end
        if (ack_ok || error) begin
            compared++;
            if (ack_ok && error) begin
                mismatched++;
                $display("FAIL ack_err_exclusive: got ack_ok=1 error=1, expected only one");
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        tx_idle = 1'b1;
        rx_receive = 1'b0;
        {btnU, btnL, btnD, btnR, btnC} = 5'b0;
        repeat (5) @(negedge clk);
        exp_tx_q.delete();
        reset_n = 1'b1;
    endtask

    // mask bits: 0=U 1=L 2=D 3=R 4=C
    task automatic press(input logic [4:0] m, output int c0);
        @(negedge clk);
        c0 = cyc;
        {btnC, btnR, btnD, btnL, btnU} = m;
        repeat (4) @(negedge clk);
        {btnC, btnR, btnD, btnL, btnU} = 5'b0;
    endtask

    task automatic drive_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_receive = 1'b1;
        @(posedge clk);
        #1 rx_receive = 1'b0;
        $display("rx byte %02h at cycle %0d", b, cyc);
    endtask

    // which: 0 = tx_transmit, 1 = ack_ok, 2 = error
    task automatic wait_sig(input int which, input int budget, input string name,
                            output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((which == 0 && tx_transmit) || (which == 1 && ack_ok) ||
                (which == 2 && error)) begin
                at = cyc;
                ok = 1'b1;
                return;
            end
        end
        compared++;
        mismatched++;
        $display("FAIL %s: got no pulse within %0d cycles, expected one", name, budget);
    endtask

    task automatic test_reset();
        int seen;
        do_reset();
        @(negedge clk);
        compared++;
        if ({tx_data, tx_transmit, busy, ack_ok, error, last_cmd, ack_count, err_count} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got tx=%02h txs=%b busy=%b ack=%b err=%b last=%02h ac=%0d ec=%0d, expected all 0",
                     tx_data, tx_transmit, busy, ack_ok, error, last_cmd, ack_count, err_count);
        end
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_transmit) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL reset_idle_tx: got %0d tx pulses, expected 0", seen);
        end
        $display("test_reset done");
    endtask

    task automatic test_ack();
        int c0, at, ta;
        bit ok;
        do_reset();
        exp_tx_q.push_back(8'h64);
        press(5'b01000, c0);
        wait_sig(0, 20, "ack_tx", at, ok);
        compared++;
        if (at - c0 !== 6) begin
            mismatched++;
            $display("FAIL tx_latency: got %0d edges, expected 6", at - c0);
        end
        repeat (19) @(negedge clk);
        drive_rx(8'h44);
        wait_sig(1, 5, "ack_ok", ta, ok);
        compared++;
        if (ack_count !== 8'd1 || last_cmd !== 8'h64 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL ack_stats: got ac=%0d last=%02h busy=%b, expected 1/64/1",
                     ack_count, last_cmd, busy);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_fall: got %b, expected 0", busy);
        end
        $display("test_ack done");
    endtask

    task automatic test_retry_error();
        int c0, t0, t1, t2, te, start;
        bit ok;
        do_reset();
        sw = 2'b10;
        repeat (MR + 1) exp_tx_q.push_back(8'h6D);
        start = tx_pulses;
        press(5'b10000, c0);
        wait_sig(0, 20, "retry_tx0", t0, ok);
        wait_sig(0, 2 * TO, "retry_tx1", t1, ok);
        wait_sig(0, 2 * TO, "retry_tx2", t2, ok);
        wait_sig(2, 2 * TO, "retry_error", te, ok);
        compared++;
        if (t1 - t0 !== TO + 1 || t2 - t1 !== TO + 1 || te - t2 !== TO) begin
            mismatched++;
            $display("FAIL retry_spacing: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     t1 - t0, t2 - t1, te - t2, TO + 1, TO + 1, TO);
        end
        compared++;
        if (err_count !== 8'd1 || ack_count !== 8'd0) begin
            mismatched++;
            $display("FAIL retry_stats: got ec=%0d ac=%0d, expected 1/0", err_count, ack_count);
        end
        repeat (20) @(negedge clk);
        compared++;
        if (tx_pulses - start !== MR + 1) begin
            mismatched++;
            $display("FAIL retry_count: got %0d sends, expected %0d", tx_pulses - start, MR + 1);
        end
        $display("test_retry_error done");
    endtask

    task automatic test_wrong_ack();
        int c0, at, seen;
        bit ok;
        do_reset();
        exp_tx_q.push_back(8'h77);
        press(5'b00001, c0);
        wait_sig(0, 20, "wrong_tx", at, ok);
        repeat (10) @(negedge clk);
        drive_rx(8'h41);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack_ok) seen++;
        end
        compared++;
        if (seen !== 0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL wrong_ack_ignored: got ack pulses=%0d busy=%b, expected 0/1", seen, busy);
        end
        drive_rx(8'h57);
        wait_sig(1, 5, "right_ack", at, ok);
        compared++;
        if (ack_count !== 8'd1) begin
            mismatched++;
            $display("FAIL wrong_ack_count: got %0d, expected 1", ack_count);
        end
        $display("test_wrong_ack done");
    endtask

    task automatic test_newest_wins();
        int c0, at;
        bit ok;
        do_reset();
        exp_tx_q.push_back(8'h77);
        press(5'b00001, c0);
        wait_sig(0, 20, "busy_tx", at, ok);
        press(5'b00010, c0);
        press(5'b00100, c0);
        exp_tx_q.push_back(8'h73);
        drive_rx(8'h57);
        wait_sig(1, 5, "first_ack", at, ok);
        wait_sig(0, 20, "newest_tx", at, ok);
        compared++;
        if (last_cmd !== 8'h73) begin
            mismatched++;
            $display("FAIL newest_last_cmd: got %02h, expected 73", last_cmd);
        end
        drive_rx(8'h53);
        wait_sig(1, 5, "second_ack", at, ok);
        repeat (20) @(negedge clk);
        compared++;
        if (ack_count !== 8'd2 || exp_tx_q.size() !== 0) begin
            mismatched++;
            $display("FAIL newest_final: got ac=%0d pending_exp=%0d, expected 2/0",
                     ack_count, exp_tx_q.size());
        end
        $display("test_newest_wins done");
    endtask

    task automatic test_priority();
        int c0, at;
        bit ok;
        do_reset();
        exp_tx_q.push_back(8'h61);
        press(5'b01010, c0);
        wait_sig(0, 20, "prio_tx", at, ok);
        drive_rx(8'h41);
        wait_sig(1, 5, "prio_ack", at, ok);
        compared++;
        if (last_cmd !== 8'h61 || ack_count !== 8'd1) begin
            mismatched++;
            $display("FAIL priority: got last=%02h ac=%0d, expected 61/1", last_cmd, ack_count);
        end
        $display("test_priority done");
    endtask

    task automatic test_tx_idle_and_reset();
        int c0, at, seen, errs;
        bit ok;
        do_reset();
        tx_idle = 1'b0;
        exp_tx_q.push_back(8'h64);
        press(5'b01000, c0);
        seen = 0;
        errs = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx_transmit) seen++;
            if (error) errs++;
        end
        compared++;
        if (seen !== 0 || errs !== 0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL tx_idle_hold: got tx=%0d err=%0d busy=%b, expected 0/0/1", seen, errs, busy);
        end
        c0 = cyc;
        tx_idle = 1'b1;
        wait_sig(0, 10, "tx_idle_release", at, ok);
        compared++;
        if (at - c0 !== 1) begin
            mismatched++;
            $display("FAIL tx_idle_latency: got %0d edges, expected 1", at - c0);
        end
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        compared++;
        if (busy !== 1'b0 || ack_count !== 8'd0 || err_count !== 8'd0 ||
            last_cmd !== 8'h00 || tx_transmit !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: got busy=%b ac=%0d ec=%0d last=%02h txs=%b, expected all 0",
                     busy, ack_count, err_count, last_cmd, tx_transmit);
        end
        seen = 0;
        errs = 0;
        repeat (250) begin
            @(negedge clk);
            if (tx_transmit) seen++;
            if (error) errs++;
        end
        compared++;
        if (seen !== 0 || errs !== 0) begin
            mismatched++;
            $display("FAIL after_reset_quiet: got tx=%0d err=%0d, expected 0/0", seen, errs);
        end
        $display("test_tx_idle_and_reset done");
    endtask

    initial begin
        test_reset();
        test_ack();
        test_retry_error();
        test_wrong_ack();
        test_newest_wins();
        test_priority();
        test_tx_idle_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_command_sender.md
# uart_command_sender

Initiator end of the board-to-board circle-control link: converts button presses into single-byte ASCII commands, sends them through `uart_transmitter`, and waits for the uppercase acknowledge byte that the receiving display system echoes back through `uart_receiver`. Each command gets a bounded timeout and a bounded number of retries. Outcomes are reported as strobes and counters for LEDs and the seven-segment debug display. It sits beside the two UART blocks on the `clk` domain of the controller board.

## Interface
- `TIMEOUT_CYCLES`, 1000000, clk cycles to wait for an ack per attempt (10 ms at 100 MHz); minimum value 2.
- `MAX_RETRY`, 3, re-sends after the first attempt before the command is declared failed.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `btnU`, `btnL`, `btnD`, `btnR`, `btnC`  in  1 each  raw buttons, already debounced, asynchronous to `clk`.
- `sw`  in  2  colour select for `btnC`.
- `tx_data`  out  8  byte to `uart_transmitter`.
- `tx_transmit`  out  1  one-cycle send strobe.
- `tx_idle`  in  1  transmitter ready.
- `rx_data`  in  8  byte from `uart_receiver`.
- `rx_receive`  in  1  one-cycle byte-valid strobe.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `ack_ok`  out  1  one-cycle pulse when the ack is matched.
- `error`  out  1  one-cycle pulse when retries are exhausted.
- `last_cmd`  out  8  last command byte accepted into the FSM.
- `ack_count`  out  8  acked commands; saturates at 255.
- `err_count`  out  8  failed commands; saturates at 255.

## Operation
**Input capture**
- Each button passes through a 2-flop synchronizer, then a registered rising-edge detector.

**Command encoding**
- Priority when edges coincide: U > L > D > R > C.
- Direction commands and their acks:
  - U sends `w` (0x77), ack `W` (0x57).
  - L sends `a` (0x61), ack `A` (0x41).
  - D sends `s` (0x73), ack `S` (0x53).
  - R sends `d` (0x64), ack `D` (0x44).
- C sends a colour command selected by `sw`:
  - `sw`=00: 0x20, ack 0x5A.
  - `sw`=01: `c` (0x63), ack 0x43.
  - `sw`=10: `m` (0x6D), ack 0x4D.
  - `sw`=11: `y` (0x79), ack 0x59.
  - `sw` is sampled in the same cycle as the C edge.

**Pending buffer**
- One-entry register holding a command byte plus a valid flag.
- A new edge overwrites it (newest wins) in any state.
- An edge in the same cycle that IDLE consumes the pending entry re-fills it.

**FSM: IDLE, SEND, WAIT_ACK**
- IDLE:
  - If pending is valid: load the command, compute the expected ack, clear pending, set `last_cmd`, clear the retry counter, go to SEND.
- SEND:
  - When `tx_idle`=1, drive `tx_data`=cmd and assert `tx_transmit` for exactly one cycle.
  - Clear the timeout counter and go to WAIT_ACK.
  - While `tx_idle`=0, wait in SEND with no timeout.
- WAIT_ACK:
  - The timeout counter increments every cycle.
  - `rx_receive`=1 with `rx_data`=expected ack: pulse `ack_ok`, increment `ack_count`, go to IDLE.
  - `rx_receive` with any other byte: ignore it; the counter keeps running.
  - Counter reaches `TIMEOUT_CYCLES`-1 with retry < `MAX_RETRY`: increment retry, go to SEND.
  - Counter reaches `TIMEOUT_CYCLES`-1 with retry = `MAX_RETRY`: pulse `error`, increment `err_count`, go to IDLE.
  - Ack and timeout in the same cycle: the ack wins.
- `rx_receive` outside WAIT_ACK is ignored.

**Widths**
- The timeout counter is wide enough for `TIMEOUT_CYCLES`.
- The retry counter is wide enough for `MAX_RETRY`.
- Both stat counters saturate at 255; they never wrap.

## Timing
- Reset (`reset_n` low on a `clk` edge):
  - All outputs are 0, FSM is IDLE, pending is invalid.
  - Synchronizers and edge registers are cleared.
  - Takes effect mid-operation: an in-flight command is abandoned without an `error` pulse, and no `tx_transmit` is issued in the cycle after reset.
- Button rise sampled at edge n: pending is valid after edge n+3. With the FSM idle and `tx_idle`=1, `tx_transmit` is high in cycle n+5.
- `ack_ok` and `error` are high in the cycle after the deciding condition and are mutually exclusive.
- A command with no ack occupies exactly (`MAX_RETRY`+1) attempts.
  - Each attempt is `TIMEOUT_CYCLES` cycles in WAIT_ACK, plus the SEND wait for `tx_idle`.
  - Exactly `MAX_RETRY`+1 `tx_transmit` pulses are issued.
- `busy` is registered. It rises the cycle after IDLE accepts a command and falls the cycle after return to IDLE.

## Test plan
All scenarios use `TIMEOUT_CYCLES`=100 and `MAX_RETRY`=2.
- Reset hold 5 cycles, release -> all outputs 0 and `busy`=0; no `tx_transmit` within 50 cycles of idle inputs.
- `btnR` pulse, `tx_idle`=1, responder returns 0x44 20 cycles after the send -> one `tx_transmit` with `tx_data`=0x64, then `ack_ok` pulse, `ack_count`=1, `last_cmd`=0x64.
- `btnC` with `sw`=10 and no response -> three `tx_transmit` pulses of 0x6D spaced about 100 cycles apart, then one `error` pulse, `err_count`=1, `ack_count` unchanged.
- `btnU` then, during WAIT_ACK, 0x41 arrives followed by 0x57 -> 0x41 is ignored; `ack_ok` follows 0x57; `ack_count`=1.
- `btnL` while busy, then `btnD` while still busy -> after the first ack the next command sent is 0x73 only (newest wins); 0x61 is never sent.
- `tx_idle` held 0 for 500 cycles after an edge -> no `tx_transmit` and no timeout; the send occurs the cycle after `tx_idle` rises. Separately, assert `reset_n` mid-WAIT_ACK -> `busy` 0, no `error`, counters 0.
